// File: rtl/pe_pkg.sv
// Shared types and constants for the polynomial engine datapath.
package pe_pkg;

    // Default polynomial length (coefficients per polynomial).
    localparam int N_COEFF_DEFAULT = 256;

    // Supported moduli.
    localparam logic [22:0] Q_DILITHIUM = 23'd8380417;
    localparam logic [22:0] Q_KYBER     = 23'd3329;

    // Modulus select encoding used on mode_i / select_i.
    localparam logic MODE_DILITHIUM = 1'b0;
    localparam logic MODE_KYBER     = 1'b1;

    // One polynomial coefficient, wide enough for the Dilithium modulus.
    typedef logic [22:0] coeff_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pwm_state_t;

    // Modulus selected by a mode bit.
    function automatic coeff_t modulus_of(input logic mode);
        coeff_t q;
        if (mode == MODE_KYBER) begin
            q = Q_KYBER;
        end else begin
            q = Q_DILITHIUM;
        end
        return q;
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: c = a*b mod q, q chosen by select_i.
// Operands may be unreduced; the full product is reduced here.
module mod_mul
    import pe_pkg::*;
(
    input  coeff_t a_i,
    input  coeff_t b_i,
    input  logic   select_i,
    output coeff_t c_o
);

    logic [45:0] prod_s;
    logic [45:0] q_s;

    // Full-width product followed by reduction against the selected modulus.
    always_comb begin
        prod_s = {23'd0, a_i} * {23'd0, b_i};
        q_s    = {23'd0, modulus_of(select_i)};
        c_o    = coeff_t'(prod_s % q_s);
    end

endmodule

// File: rtl/pwm_seq.sv
// Pointwise polynomial multiply sequencer: streams both operand RAMs through
// mod_mul and writes c[k] = a[k]*b[k] mod q into the result RAM.
// Pipeline: read issue (t) -> RAM data captured (t+1) -> product registered
// (t+2) -> write visible on the output ports during t+3.
module pwm_seq
    import pe_pkg::*;
#(
    parameter int N_COEFF = N_COEFF_DEFAULT,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 23
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              mode_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] a_rdata_i,
    input  logic [DATA_W-1:0] b_rdata_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFF - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

    // Control state
    pwm_state_t        state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;

    // Registered status outputs
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;

    // Stage 1: read issued, address tracked alongside
    logic              s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

    // Stage 2: operands captured from RAM
    logic              s2_vld_q, s2_vld_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;

    // Stage 3: result registered onto the write port
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    coeff_t            mul_c_s;

    mod_mul u_mod_mul (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .select_i (mode_q),
        .c_o      (mul_c_s)
    );

    // Next-state logic: job control, read counter, status outputs.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                if (start_i) begin
                    state_d = RUN;
                    mode_d  = mode_i;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Leave on the issue of the last address so the counter never wraps.
                if (rd_cnt_q == LAST_ADDR) begin
                    state_d  = DRAIN;
                    rd_cnt_d = '0;
                end else begin
                    state_d  = RUN;
                    rd_cnt_d = rd_cnt_q + ADDR_ONE;
                end
            end
            DRAIN: begin
                rd_cnt_d = '0;
                if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                rd_cnt_d = '0;
                state_d  = IDLE;
            end
            default: begin
                rd_cnt_d = '0;
                state_d  = IDLE;
            end
        endcase

        busy_d  = (state_d == RUN) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
        rd_en_d = (state_d == RUN);
    end

    // Datapath next-state: advance valid/address with the data through the stages.
    always_comb begin
        s1_vld_d  = (state_q == RUN);
        s1_addr_d = rd_cnt_q;

        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        if (s1_vld_q) begin
            op_a_d = a_rdata_i;
            op_b_d = b_rdata_i;
        end else begin
            op_a_d = '0;
            op_b_d = '0;
        end

        wr_en_d = s2_vld_q;
        if (s2_vld_q) begin
            wr_addr_d = s2_addr_q;
            wr_data_d = DATA_W'(mul_c_s);
        end else begin
            wr_addr_d = '0;
            wr_data_d = '0;
        end
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            mode_q    <= MODE_DILITHIUM;
            rd_cnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rd_cnt_q  <= rd_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s2_vld_q  <= s2_vld_d;
            s2_addr_q <= s2_addr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_cnt_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_pwm_seq.sv
// Bench for pwm_seq: cycle-level timing model checked every cycle plus
// directed jobs with hand-computed expectations.
module tb_pwm_seq;

    localparam int N      = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 23;

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic              start_i;
    logic              mode_i;
    logic              busy_o;
    logic              done_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] a_rdata_i;
    logic [DATA_W-1:0] b_rdata_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;

    always #5 clk = ~clk;

    pwm_seq #(.N_COEFF(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .a_rdata_i (a_rdata_i),
        .b_rdata_i (b_rdata_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
    );

    // Operand RAMs (1-cycle read latency) and result RAM.
    logic [DATA_W-1:0] a_mem [N];
    logic [DATA_W-1:0] b_mem [N];
    logic [DATA_W-1:0] c_mem [N];

    always @(posedge clk) begin
        if (rd_en_o === 1'b1) begin
            a_rdata_i <= a_mem[rd_addr_o];
            b_rdata_i <= b_mem[rd_addr_o];
        end
    end

    // Timing model: a job is a window of N+4 cycles after the start cycle c0.
    int   cyc = 0;
    logic m_active = 1'b0;
    int   m_c0 = 0;
    logic m_mode = 1'b0;

    always @(posedge clk) begin
        if (rst_n_i !== 1'b1) begin
            m_active <= 1'b0;
        end else if (!m_active && start_i) begin
            m_active <= 1'b1;
            m_c0     <= cyc;
            m_mode   <= mode_i;
        end else if (m_active && (cyc - m_c0 == N + 4)) begin
            m_active <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic longint exp_prod(input int k, input logic md);
        longint q;
        q = md ? 64'd3329 : 64'd8380417;
        return (longint'(a_mem[k]) * longint'(b_mem[k])) % q;
    endfunction

    // Per-cycle compare against the timing model.
    always @(negedge clk) begin
        if (chk_en) begin
            int  j;
            bit  e_busy, e_done, e_rd, e_wr;
            j      = cyc - m_c0;
            e_busy = m_active && (j >= 1) && (j <= N + 3);
            e_done = m_active && (j == N + 4);
            e_rd   = m_active && (j >= 1) && (j <= N);
            e_wr   = m_active && (j >= 4) && (j <= N + 3);
            chk("busy", longint'(busy_o), longint'(e_busy));
            chk("done", longint'(done_o), longint'(e_done));
            chk("rd_en", longint'(rd_en_o), longint'(e_rd));
            chk("wr_en", longint'(wr_en_o), longint'(e_wr));
            if (e_rd) chk("rd_addr", longint'(rd_addr_o), longint'(j - 1));
            if (e_wr) begin
                chk("wr_addr", longint'(wr_addr_o), longint'(j - 4));
                chk("wr_data", longint'(wr_data_o), exp_prod(j - 4, m_mode));
            end
        end
    end

    // Monitor: capture writes into the result RAM and job statistics.
    int wr_cnt, done_cnt, busy_cnt, first_wr_cyc, done_cyc;
    bit seen_wr;

    always @(negedge clk) begin
        if (wr_en_o === 1'b1) begin
            c_mem[wr_addr_o] = wr_data_o;
            if (!seen_wr) first_wr_cyc = cyc;
            seen_wr = 1'b1;
            wr_cnt++;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o === 1'b1) busy_cnt++;
    end

    int   job_c0;
    logic [ADDR_W:0] rd_snap;

    // One job: start in the next cycle, run through the done cycle (c0+260).
    task automatic run_job(input logic m, input int tog_at, input int s1_at,
                           input int s2_at, input int rst_at);
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = m;
        job_c0  = cyc;
        wr_cnt = 0; done_cnt = 0; busy_cnt = 0; seen_wr = 1'b0;
        first_wr_cyc = -1; done_cyc = -1;
        for (int i = 0; i < N; i++) c_mem[i] = 23'h7FFFFF;
        for (int j = 1; j <= N + 4; j++) begin
            @(negedge clk);
            start_i = (j == s1_at) || (j == s2_at);
            if (j == tog_at) mode_i = ~mode_i;
            rst_n_i = (j == rst_at) ? 1'b0 : 1'b1;
            if (j == 1) rd_snap = {rd_en_o, rd_addr_o};
            if ((rst_at >= 0) && (j == rst_at + 1)) begin
                chk("rst_outs_zero",
                    longint'({busy_o, done_o, rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, wr_data_o}),
                    64'd0);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        #1;
    endtask

    function automatic int count_ne(input longint v);
        int bad;
        bad = 0;
        for (int k = 0; k < N; k++) if (longint'(c_mem[k]) != v) bad++;
        return bad;
    endfunction

    int prev_done;
    int bad;

    initial begin
        rst_n_i = 1'b0;
        start_i = 1'b0;
        mode_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outs",
            longint'({busy_o, done_o, rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, wr_data_o}), 64'd0);
        rst_n_i = 1'b1;
        idle(2);

        // Kyber timing job: a[k]=k, b[k]=k+1.
        for (int k = 0; k < N; k++) begin
            a_mem[k] = DATA_W'(k);
            b_mem[k] = DATA_W'(k + 1);
        end
        run_job(1'b1, -1, -1, -1, -1);
        idle(3);
        chk("k_rd_first", longint'(rd_snap), 64'h100);
        chk("k_first_wr_ofs", first_wr_cyc - job_c0, 4);
        chk("k_done_ofs", done_cyc - job_c0, 260);
        chk("k_c0", longint'(c_mem[0]), 0);
        chk("k_c255", longint'(c_mem[255]), 2029);
        chk("k_wr_cnt", wr_cnt, 256);
        chk("k_done_cnt", done_cnt, 1);
        chk("k_busy_cycles", busy_cnt, 259);

        // Dilithium: (q-1)^2 = 1 mod q.
        for (int k = 0; k < N; k++) begin
            a_mem[k] = 23'd8380416;
            b_mem[k] = 23'd8380416;
        end
        run_job(1'b0, -1, -1, -1, -1);
        idle(3);
        chk("d_all_ones_a", count_ne(1), 0);
        chk("d_wr_cnt_a", wr_cnt, 256);

        // Dilithium: 4190209*2 = q+1 = 1 mod q.
        for (int k = 0; k < N; k++) begin
            a_mem[k] = 23'd4190209;
            b_mem[k] = 23'd2;
        end
        run_job(1'b0, -1, -1, -1, -1);
        idle(3);
        chk("d_all_ones_b", count_ne(1), 0);

        // Mode latch: mode_i flips to Dilithium while k=50 is being read.
        for (int k = 0; k < N; k++) begin
            a_mem[k] = DATA_W'(k * 12345 + 7);
            b_mem[k] = DATA_W'(k * 777 + 3);
        end
        run_job(1'b1, 51, -1, -1, -1);
        idle(3);
        bad = 0;
        for (int k = 0; k < N; k++) begin
            longint e;
            e = ((longint'(k) * 12345 + 7) * (longint'(k) * 777 + 3)) % 3329;
            if (longint'(c_mem[k]) != e) bad++;
        end
        chk("latch_kyber_results", bad, 0);
        chk("latch_wr_cnt", wr_cnt, 256);

        // Start pulses while busy and in the done cycle are ignored.
        run_job(1'b1, -1, 100, 260, -1);
        idle(5);
        chk("swb_wr_cnt", wr_cnt, 256);
        chk("swb_done_cnt", done_cnt, 1);

        // Reset mid-job: writes k=0..97 happen, nothing afterwards.
        run_job(1'b1, -1, -1, -1, 101);
        idle(3);
        chk("rst_wr_cnt", wr_cnt, 98);
        chk("rst_done_cnt", done_cnt, 0);
        run_job(1'b0, -1, -1, -1, -1);
        idle(3);
        chk("post_rst_wr_cnt", wr_cnt, 256);
        chk("post_rst_done_cnt", done_cnt, 1);

        // Back-to-back: second start in the cycle after done.
        for (int k = 0; k < N; k++) begin
            a_mem[k] = DATA_W'(k);
            b_mem[k] = DATA_W'(k + 1);
        end
        run_job(1'b1, -1, -1, -1, -1);
        prev_done = done_cyc;
        run_job(1'b1, -1, -1, -1, -1);
        idle(3);
        chk("b2b_gap", job_c0 - prev_done, 1);
        chk("b2b_rd_first", longint'(rd_snap), 64'h100);
        chk("b2b_first_wr_ofs", first_wr_cyc - job_c0, 4);
        chk("b2b_done_ofs", done_cyc - job_c0, 260);
        chk("b2b_c255", longint'(c_mem[255]), 2029);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
